// File: rtl/msrh_credit_return_master_if.sv
// Credit request/return bundle between dispatch, the credit master and the resource's return slave.
// The master modport is the credit-issuing side; slave is its environment.
interface msrh_credit_return_master_if #(
  parameter int unsigned MAX_CREDITS = 16
);
  localparam int unsigned CNT_W = $clog2(MAX_CREDITS) + 1;

  logic             i_get_credit;
  logic [CNT_W-1:0] i_credit_val;
  logic             o_credit_grant;
  logic             o_no_credits;
  logic             i_return_valid;
  logic [CNT_W-1:0] i_return_val;
  logic [CNT_W-1:0] o_credits;
  logic             o_all_returned;
  logic             o_overflow;

  modport master (
    input  i_get_credit,
    input  i_credit_val,
    input  i_return_valid,
    input  i_return_val,
    output o_credit_grant,
    output o_no_credits,
    output o_credits,
    output o_all_returned,
    output o_overflow
  );

  modport slave (
    output i_get_credit,
    output i_credit_val,
    output i_return_valid,
    output i_return_val,
    input  o_credit_grant,
    input  o_no_credits,
    input  o_credits,
    input  o_all_returned,
    input  o_overflow
  );
endinterface

// File: rtl/msrh_credit_return_master.sv
// Credit-issuing master: grants dispatch requests against the available credit count and
// absorbs credit returns through a one-cycle staging register.
module msrh_credit_return_master #(
  parameter int unsigned MAX_CREDITS = 16
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset_n,
  msrh_credit_return_master_if.master          credit_if
);
  localparam int unsigned CNT_W = $clog2(MAX_CREDITS) + 1;
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_CREDITS);
  localparam logic [CNT_W:0]   MaxCntWide = (CNT_W + 1)'(MAX_CREDITS);

  logic [CNT_W-1:0] r_credits;
  logic             r_ret_valid;
  logic [CNT_W-1:0] r_ret_val;
  logic             r_overflow;

  logic             no_credits;
  logic             credit_grant;
  logic [CNT_W:0]   credits_next;

  // Staged returns are deliberately excluded from the grant check.
  always_comb begin
    no_credits   = credit_if.i_get_credit & (r_credits < credit_if.i_credit_val);
    credit_grant = credit_if.i_get_credit & ~no_credits;
  end

  // One extra bit holds a return that pushes the count past MAX_CREDITS; grants never
  // exceed r_credits, so the subtraction cannot wrap.
  always_comb begin
    credits_next = {1'b0, r_credits};
    if (credit_grant) begin
      credits_next = credits_next - {1'b0, credit_if.i_credit_val};
    end
    if (r_ret_valid) begin
      credits_next = credits_next + {1'b0, r_ret_val};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_credits   <= MaxCnt;
      r_ret_valid <= 1'b0;
      r_ret_val   <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_ret_valid <= credit_if.i_return_valid;
      r_ret_val   <= credit_if.i_return_val;
      if (credits_next > MaxCntWide) begin
        r_credits  <= MaxCnt;
        r_overflow <= 1'b1;
      end else begin
        r_credits <= credits_next[CNT_W-1:0];
      end
    end
  end

`ifdef SIMULATION
  always_ff @(posedge i_clk) begin
    if (i_reset_n) begin
      assert (credits_next <= MaxCntWide)
        else $error("credit counter overflow: next=%0d max=%0d", credits_next, MAX_CREDITS);
    end
  end
`endif

  assign credit_if.o_no_credits   = no_credits;
  assign credit_if.o_credit_grant = credit_grant;
  assign credit_if.o_credits      = r_credits;
  assign credit_if.o_all_returned = (r_credits == MaxCnt) & ~r_ret_valid;
  assign credit_if.o_overflow     = r_overflow;

endmodule

// File: tb/tb_msrh_credit_return_master.sv
// Directed bench for msrh_credit_return_master with hand-computed expectations.
module tb_msrh_credit_return_master;
  localparam int unsigned MaxCredits = 16;
  localparam int unsigned CntW = 5;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  msrh_credit_return_master_if #(.MAX_CREDITS(MaxCredits)) crif ();

  msrh_credit_return_master #(.MAX_CREDITS(MaxCredits)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .credit_if (crif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic get, input int val, input logic rv, input int rval);
    crif.i_get_credit   = get;
    crif.i_credit_val   = CntW'(val);
    crif.i_return_valid = rv;
    crif.i_return_val   = CntW'(rval);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 0, 1'b0, 0);
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();
    checks++;
    if (crif.o_credits !== 5'd16) begin
      failures++; $display("FAIL reset_credits got=%0d exp=16", crif.o_credits);
    end
    checks++;
    if (crif.o_all_returned !== 1'b1) begin
      failures++; $display("FAIL reset_all_returned got=%0b exp=1", crif.o_all_returned);
    end
    checks++;
    if (crif.o_overflow !== 1'b0) begin
      failures++; $display("FAIL reset_overflow got=%0b exp=0", crif.o_overflow);
    end
    checks++;
    if (crif.o_no_credits !== 1'b0 || crif.o_credit_grant !== 1'b0) begin
      failures++;
      $display("FAIL reset_req got nc=%0b gr=%0b exp nc=0 gr=0",
               crif.o_no_credits, crif.o_credit_grant);
    end
  endtask

  task automatic test_consume();
    int exp_cred;
    exp_cred = 16;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4, 1'b0, 0);
      checks++;
      if (crif.o_credit_grant !== 1'b1) begin
        failures++; $display("FAIL consume_grant[%0d] got=%0b exp=1", i, crif.o_credit_grant);
      end
      tick();
      exp_cred -= 4;
      checks++;
      if (crif.o_credits !== CntW'(exp_cred)) begin
        failures++; $display("FAIL consume_credits[%0d] got=%0d exp=%0d", i, crif.o_credits, exp_cred);
      end
    end
    drive(1'b1, 1, 1'b0, 0);
    checks++;
    if (crif.o_no_credits !== 1'b1 || crif.o_credit_grant !== 1'b0) begin
      failures++;
      $display("FAIL empty_stall got nc=%0b gr=%0b exp nc=1 gr=0",
               crif.o_no_credits, crif.o_credit_grant);
    end
    tick();
    checks++;
    if (crif.o_credits !== 5'd0) begin
      failures++; $display("FAIL empty_hold got=%0d exp=0", crif.o_credits);
    end
  endtask

  task automatic test_return_latency();
    drive(1'b0, 0, 1'b1, 3);
    tick();
    drive(1'b1, 3, 1'b0, 0);
    checks++;
    if (crif.o_no_credits !== 1'b1 || crif.o_credits !== 5'd0) begin
      failures++;
      $display("FAIL staged_refuse got nc=%0b cred=%0d exp nc=1 cred=0",
               crif.o_no_credits, crif.o_credits);
    end
    checks++;
    if (crif.o_all_returned !== 1'b0) begin
      failures++; $display("FAIL staged_all_returned got=%0b exp=0", crif.o_all_returned);
    end
    tick();
    checks++;
    if (crif.o_credits !== 5'd3 || crif.o_credit_grant !== 1'b1) begin
      failures++;
      $display("FAIL return_visible got cred=%0d gr=%0b exp cred=3 gr=1",
               crif.o_credits, crif.o_credit_grant);
    end
    tick();
    drive(1'b0, 0, 1'b0, 0);
    checks++;
    if (crif.o_credits !== 5'd0) begin
      failures++; $display("FAIL return_consumed got=%0d exp=0", crif.o_credits);
    end
  endtask

  task automatic test_simultaneous();
    drive(1'b0, 0, 1'b1, 5);
    tick();
    drive(1'b0, 0, 1'b1, 4);
    tick();
    drive(1'b1, 2, 1'b0, 0);
    checks++;
    if (crif.o_credits !== 5'd5 || crif.o_credit_grant !== 1'b1) begin
      failures++;
      $display("FAIL simul_pre got cred=%0d gr=%0b exp cred=5 gr=1",
               crif.o_credits, crif.o_credit_grant);
    end
    tick();
    checks++;
    if (crif.o_credits !== 5'd7) begin
      failures++; $display("FAIL simul_apply got=%0d exp=7", crif.o_credits);
    end
    drive(1'b1, 0, 1'b1, 0);
    checks++;
    if (crif.o_credit_grant !== 1'b1) begin
      failures++; $display("FAIL zero_grant got=%0b exp=1", crif.o_credit_grant);
    end
    tick();
    drive(1'b1, 0, 1'b0, 0);
    tick();
    drive(1'b0, 0, 1'b0, 0);
    checks++;
    if (crif.o_credits !== 5'd7) begin
      failures++; $display("FAIL zero_unchanged got=%0d exp=7", crif.o_credits);
    end
  endtask

  task automatic test_overflow();
    drive(1'b0, 0, 1'b1, 9);
    tick();
    drive(1'b0, 0, 1'b0, 0);
    tick();
    checks++;
    if (crif.o_credits !== 5'd16 || crif.o_all_returned !== 1'b1 || crif.o_overflow !== 1'b0) begin
      failures++;
      $display("FAIL refill got cred=%0d all=%0b ovf=%0b exp cred=16 all=1 ovf=0",
               crif.o_credits, crif.o_all_returned, crif.o_overflow);
    end
    drive(1'b0, 0, 1'b1, 1);
    tick();
    drive(1'b0, 0, 1'b0, 0);
    tick();
    checks++;
    if (crif.o_credits !== 5'd16 || crif.o_overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow got cred=%0d ovf=%0b exp cred=16 ovf=1",
               crif.o_credits, crif.o_overflow);
    end
    drive(1'b1, 3, 1'b0, 0);
    tick();
    drive(1'b0, 0, 1'b1, 3);
    checks++;
    if (crif.o_credits !== 5'd13 || crif.o_overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_sticky1 got cred=%0d ovf=%0b exp cred=13 ovf=1",
               crif.o_credits, crif.o_overflow);
    end
    tick();
    drive(1'b0, 0, 1'b0, 0);
    tick();
    checks++;
    if (crif.o_credits !== 5'd16 || crif.o_overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_sticky2 got cred=%0d ovf=%0b exp cred=16 ovf=1",
               crif.o_credits, crif.o_overflow);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 10, 1'b1, 5);
    tick();
    drive(1'b0, 0, 1'b0, 0);
    checks++;
    if (crif.o_credits !== 5'd6 || crif.o_all_returned !== 1'b0) begin
      failures++;
      $display("FAIL pre_reset got cred=%0d all=%0b exp cred=6 all=0",
               crif.o_credits, crif.o_all_returned);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (crif.o_credits !== 5'd16 || crif.o_all_returned !== 1'b1 || crif.o_overflow !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got cred=%0d all=%0b ovf=%0b exp cred=16 all=1 ovf=0",
               crif.o_credits, crif.o_all_returned, crif.o_overflow);
    end
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (crif.o_credits !== 5'd16 || crif.o_overflow !== 1'b0 || crif.o_all_returned !== 1'b1) begin
      failures++;
      $display("FAIL discard_staged got cred=%0d ovf=%0b all=%0b exp cred=16 ovf=0 all=1",
               crif.o_credits, crif.o_overflow, crif.o_all_returned);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    test_reset();
    test_consume();
    test_return_latency();
    test_simultaneous();
    test_overflow();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/msrh_credit_return_master.md
Name: msrh_credit_return_master

Overview:
- Credit-issuing end of the credit/return protocol.
- Sits in front of a credit-managed resource (ROB, issue queues, LSU queues) on the dispatch side.
- Tracks how many entries the downstream resource can still accept, and grants or stalls dispatch consumption requests.
- Absorbs credit returns from the resource's credit-return slave through a one-cycle staging register.

Parameters:
MAX_CREDITS, 16, number of entries in the downstream resource; also the counter reset value.
CNT_W, $clog2(MAX_CREDITS)+1, width of the credit counter and of all credit amount ports (derived; do not override).

Ports:
i_clk  input  1  clock
i_reset_n  input  1  asynchronous active-low reset
i_get_credit  input  1  dispatch requests to consume credits this cycle
i_credit_val  input  CNT_W  number of credits requested (0..MAX_CREDITS)
o_credit_grant  output  1  request accepted this cycle; dispatch may proceed
o_no_credits  output  1  current credits < i_credit_val; dispatch must stall
i_return_valid  input  1  slave returns credits this cycle
i_return_val  input  CNT_W  number of credits returned
o_credits  output  CNT_W  currently available credits (registered)
o_all_returned  output  1  o_credits == MAX_CREDITS and no return is staged (resource empty)
o_overflow  output  1  sticky error: the counter would have exceeded MAX_CREDITS

Behaviour:
- Reset (async, i_reset_n low):
  - r_credits = MAX_CREDITS; staged return cleared.
  - o_overflow = 0, o_credit_grant = 0, o_no_credits = 0, o_all_returned = 1.
- Outputs o_no_credits and o_credit_grant are combinational from r_credits and the request ports:
  - o_no_credits = i_get_credit & (r_credits < i_credit_val).
  - o_credit_grant = i_get_credit & !o_no_credits.
- A request with i_credit_val = 0 is always granted and has no effect on the counter.
- Return staging:
  - i_return_valid/i_return_val are captured into r_ret_valid/r_ret_val each cycle.
  - The staged value is added to the counter on the following edge, so returned credits become visible on o_credits 2 edges after i_return_valid is asserted.
  - Staged credits are not visible to the grant check in the cycle they are staged (conservative by design).
- Counter update each edge:
  - r_credits_next = r_credits - (o_credit_grant ? i_credit_val : 0) + (r_ret_valid ? r_ret_val : 0).
  - Compute at CNT_W+1 bits.
- Simultaneous grant and staged return in the same cycle: both are applied in one update. There is no priority and no lost credits.
- Overflow:
  - If r_credits_next > MAX_CREDITS, set o_overflow (sticky until reset) and saturate r_credits to MAX_CREDITS.
  - SIMULATION builds additionally raise an assertion error.
- Underflow cannot occur, since grants are gated by the r_credits check.
  - A grant of exactly r_credits drives the counter to 0, and o_no_credits asserts for any later non-zero request.
- o_all_returned = (r_credits == MAX_CREDITS) & !r_ret_valid.
  - Used by flush/fence logic to wait for resource drain.
- No internal flush: credits for killed entries come back through normal returns from the slave. i_return_val may be any value 0..MAX_CREDITS.
- Reset asserted mid-operation: the counter and staging register return to reset values immediately; an in-flight return is discarded.

Test Plan:
1. Reset release, no traffic → o_credits=16, o_all_returned=1, o_overflow=0, o_no_credits=0.
2. Request 4 per cycle for 4 cycles with no returns → grants on all 4; o_credits 12,8,4,0. A 5th request of 1 → o_no_credits=1, o_credit_grant=0, o_credits stays 0.
3. From o_credits=0: i_return_valid with val=3 at cycle T → o_credits=3 after edge T+2. A request of 3 is refused in cycle T+1 and granted in T+2.
4. Simultaneous events: o_credits=5, grant 2 while staged return 4 → o_credits=7 next cycle. Grant 0 with return 0 → unchanged.
5. Overflow: o_credits=16, return 1 → o_credits stays 16, o_overflow=1 and stays 1 through later normal traffic until reset.
6. Async reset mid-stream: o_credits=6 with a return staged, pulse i_reset_n low between edges → outputs immediately at reset values; after release o_credits=16 and the staged return is not applied.
